// File: rtl/edge_pkg.sv
// Shared image geometry and pixel/window types for the SPI receiver,
// raster-to-window stage and Sobel edge detector.
package edge_pkg;

    localparam int IMG_WIDTH  = 640;
    localparam int IMG_HEIGHT = 480;
    localparam int PIX_W      = 4;
    localparam int COORD_X_W  = 10;
    localparam int COORD_Y_W  = 9;

    typedef logic [PIX_W-1:0]     pixel_t;
    typedef pixel_t [0:2][0:2]    window_t;
    typedef logic [COORD_X_W-1:0] coord_x_t;
    typedef logic [COORD_Y_W-1:0] coord_y_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } raster_state_t;

    typedef struct packed {
        logic     valid;
        pixel_t   pix;
        coord_x_t x;
        coord_y_t y;
    } s0_t;

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line memory with registered read; written so that it
// maps onto block RAM. Contents are deliberately not reset.
module line_buffer_ram #(
    parameter int DEPTH = 640,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_window_buffer.sv
// Raster-to-window stage: keeps two previous lines in RAM and emits a
// registered 3x3 neighbourhood with the coordinates of its centre.
module pixel_window_buffer
    import edge_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic     mainClk,
    input  logic     nreset,
    input  pixel_t   pixelIn,
    input  logic     pixelInValid,
    input  logic     frameStart,
    output window_t  window,
    output logic     windowValid,
    output coord_x_t centreX,
    output coord_y_t centreY,
    output logic     overflow
);

    localparam int       AW     = $clog2(WIDTH);
    localparam coord_x_t X_LAST = coord_x_t'(WIDTH - 1);
    localparam coord_y_t Y_LAST = coord_y_t'(HEIGHT - 1);

    raster_state_t state, state_n;
    coord_x_t      x, x_n, px;
    coord_y_t      y, y_n, py;
    logic          overflow_n;
    logic          accept;
    s0_t           s0;

    logic [2*PIX_W-1:0] ram_q;
    logic [2*PIX_W-1:0] ram_wdata;
    pixel_t             up_pix;
    pixel_t             old_pix;

    // frameStart relabels the beat on the same cycle as (0,0)
    always_comb begin
        state_n    = state;
        x_n        = x;
        y_n        = y;
        overflow_n = overflow;
        px         = x;
        py         = y;
        if (frameStart) begin
            px         = '0;
            py         = '0;
            x_n        = '0;
            y_n        = '0;
            state_n    = ST_FILL;
            overflow_n = 1'b0;
        end
        accept = pixelInValid && (frameStart || state != ST_DONE);
        if (pixelInValid && !frameStart && state == ST_DONE) begin
            overflow_n = 1'b1;
        end
        if (accept) begin
            if (px == X_LAST) begin
                x_n = '0;
                if (py == Y_LAST) begin
                    y_n     = py;
                    state_n = ST_DONE;
                end else begin
                    y_n     = py + coord_y_t'(1);
                    state_n = (py >= coord_y_t'(1)) ? ST_STREAM : ST_FILL;
                end
            end else begin
                x_n     = px + coord_x_t'(1);
                y_n     = py;
                state_n = (py >= coord_y_t'(2)) ? ST_STREAM : ST_FILL;
            end
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_FILL;
            x        <= '0;
            y        <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            y        <= y_n;
            overflow <= overflow_n;
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            s0 <= '0;
        end else begin
            s0.valid <= accept;
            if (accept) begin
                s0.pix <= pixelIn;
                s0.x   <= px;
                s0.y   <= py;
            end
        end
    end

    assign up_pix    = ram_q[2*PIX_W-1:PIX_W];
    assign old_pix   = ram_q[PIX_W-1:0];
    assign ram_wdata = {s0.pix, up_pix};

    line_buffer_ram #(
        .DEPTH(WIDTH),
        .DW   (2 * PIX_W),
        .AW   (AW)
    ) u_lines (
        .clk    (mainClk),
        .wr_en  (s0.valid),
        .wr_addr(s0.x[AW-1:0]),
        .wr_data(ram_wdata),
        .rd_en  (accept),
        .rd_addr(px[AW-1:0]),
        .rd_data(ram_q)
    );

    // the shift register runs across line ends; windowValid masks x<2
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            window      <= '0;
            windowValid <= 1'b0;
            centreX     <= '0;
            centreY     <= '0;
        end else begin
            windowValid <= 1'b0;
            if (s0.valid) begin
                for (int r = 0; r < 3; r++) begin
                    window[r][0] <= window[r][1];
                    window[r][1] <= window[r][2];
                end
                window[0][2] <= old_pix;
                window[1][2] <= up_pix;
                window[2][2] <= s0.pix;
                if (s0.x >= coord_x_t'(2) && s0.y >= coord_y_t'(2)) begin
                    windowValid <= 1'b1;
                    centreX     <= s0.x - coord_x_t'(1);
                    centreY     <= s0.y - coord_y_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Randomised scoreboard bench for pixel_window_buffer on an 8x6 image.
module tb_pixel_window_buffer;
    import edge_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    logic     mainClk = 1'b0;
    logic     nreset = 1'b0;
    pixel_t   pixelIn = '0;
    logic     pixelInValid = 1'b0;
    logic     frameStart = 1'b0;
    window_t  window;
    logic     windowValid;
    coord_x_t centreX;
    coord_y_t centreY;
    logic     overflow;

    pixel_window_buffer #(.WIDTH(W), .HEIGHT(H)) dut (
        .mainClk     (mainClk),
        .nreset      (nreset),
        .pixelIn     (pixelIn),
        .pixelInValid(pixelInValid),
        .frameStart  (frameStart),
        .window      (window),
        .windowValid (windowValid),
        .centreX     (centreX),
        .centreY     (centreY),
        .overflow    (overflow)
    );

    always #5 mainClk = ~mainClk;

    int cyc = 0;
    always @(posedge mainClk) cyc++;

    typedef struct {
        window_t w;
        int      cx;
        int      cy;
        int      at;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     strobes = 0;
    int     last_cx = -1;
    int     last_cy = -1;
    logic [35:0] first_w;
    int     first_cx, first_cy;

    pixel_t img[H][W];
    int     mx = 0, my = 0;
    bit     mdone = 0, movf = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic pixel_t ramp(int x, int y);
        return pixel_t'((x + 8 * y) & 15);
    endfunction

    always @(negedge mainClk) begin
        exp_t e;
        if (windowValid === 1'b1) begin
            strobes++;
            if (strobes == 1) begin
                first_w  = window;
                first_cx = int'(centreX);
                first_cy = int'(centreY);
            end
            last_cx = int'(centreX);
            last_cy = int'(centreY);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got centre (%0d,%0d) expected none", centreX, centreY);
            end else begin
                e = sb.pop_front();
                chk("window", 64'(window), 64'(e.w));
                chk("centreX", 64'(centreX), 64'(e.cx));
                chk("centreY", 64'(centreY), 64'(e.cy));
                chk("strobe_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    // reference: frame store indexed by raster position
    task automatic drive(input logic v, input pixel_t p, input logic fs);
        exp_t e;
        @(posedge mainClk);
        #1;
        pixelInValid = v;
        pixelIn      = p;
        frameStart   = fs;
        if (fs) begin
            mx = 0; my = 0; mdone = 0; movf = 0;
        end
        if (v) begin
            if (mdone) begin
                movf = 1;
            end else begin
                img[my][mx] = p;
                if (mx >= 2 && my >= 2) begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            e.w[r][c] = img[my-2+r][mx-2+c];
                    e.cx = mx - 1;
                    e.cy = my - 1;
                    e.at = cyc + 2;
                    sb.push_back(e);
                end
                if (mx == W - 1) begin
                    mx = 0;
                    if (my == H - 1) mdone = 1;
                    else my++;
                end else begin
                    mx++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
    endtask

    // mode 0: back-to-back, 1: one beat in three, 2: random gaps
    task automatic send_beats(input int first, input int last, input int mode, input bit rnd);
        pixel_t p;
        for (int i = first; i <= last; i++) begin
            p = rnd ? pixel_t'($urandom) : ramp(i % W, i / W);
            drive(1'b1, p, i == 0);
            if (mode == 1) idle(2);
            else if (mode == 2) idle($urandom_range(0, 2));
        end
    endtask

    task automatic frame_checks(input string tag, input int n_strobes);
        chk({tag, "_strobes"}, 64'(strobes), 64'(n_strobes));
        chk({tag, "_last_cx"}, 64'(last_cx), 64'(W - 2));
        chk({tag, "_last_cy"}, 64'(last_cy), 64'(H - 2));
        chk({tag, "_overflow"}, 64'(overflow), 64'(movf));
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    task automatic check_zero(input string name);
        chk(name, {7'b0, window, windowValid, centreX, centreY, overflow}, 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            @(posedge mainClk);
            #1;
            pixelIn      = pixel_t'($urandom);
            pixelInValid = 1'b1;
            frameStart   = 1'($urandom);
            @(negedge mainClk);
            check_zero("reset_outputs");
        end
        @(posedge mainClk);
        #1;
        pixelInValid = 1'b0;
        frameStart   = 1'b0;
        nreset       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge mainClk);
            chk("post_reset_valid", 64'(windowValid), 64'(0));
        end

        strobes = 0;
        send_beats(0, W * H - 1, 0, 0);
        idle(4);
        frame_checks("ramp", 24);
        chk("first_window", 64'(first_w), 64'(36'h012_89A_012));
        chk("first_cx", 64'(first_cx), 64'(1));
        chk("first_cy", 64'(first_cy), 64'(1));

        strobes = 0;
        send_beats(0, W * H - 1, 1, 0);
        idle(4);
        frame_checks("gapped", 24);

        strobes = 0;
        send_beats(0, 3 * W + 2, 0, 0);
        send_beats(0, W * H - 1, 0, 1);
        idle(4);
        frame_checks("restart", 31);

        strobes = 0;
        send_beats(0, W * H - 1, 0, 1);
        drive(1'b1, pixel_t'($urandom), 1'b0);
        @(negedge mainClk);
        chk("overflow_before_49", 64'(overflow), 64'(0));
        drive(1'b1, pixel_t'($urandom), 1'b0);
        @(negedge mainClk);
        chk("overflow_after_49", 64'(overflow), 64'(1));
        idle(4);
        frame_checks("overflow", 24);
        drive(1'b0, '0, 1'b1);
        idle(1);
        @(negedge mainClk);
        chk("overflow_cleared", 64'(overflow), 64'(movf));

        send_beats(0, 3 * W + 3, 0, 1);
        @(posedge mainClk);
        #1;
        nreset       = 1'b0;
        pixelInValid = 1'b0;
        frameStart   = 1'b0;
        sb.delete();
        mx = 0; my = 0; mdone = 0; movf = 0;
        #1;
        check_zero("async_reset_outputs");
        @(posedge mainClk);
        #1;
        nreset = 1'b1;
        strobes = 0;
        send_beats(0, W * H - 1, 2, 1);
        idle(4);
        frame_checks("after_reset", 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
